// File: rtl/dic_cmd_fsm.sv
// dic_cmd_fsm: command decoder for the alarm-clock control path (run, time/alarm digit loads, alarm enables).
// Latency: ld_* strobes are combinational from det_num; state, idx, alm_sel and alarm_ena update on the next clk edge.
// No backpressure: every detector strobe is consumed the cycle it arrives. Optional macro DIC_LOAD_TIMEOUT_EN adds a load timeout.
module dic_cmd_fsm #(
    parameter int NDIG   = 4,
    parameter int NALM   = 2,
    parameter int TO_SEC = 10,
    parameter int CW     = (NALM > 1) ? $clog2(NALM) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            det_cr,
    input  logic            det_S,
    input  logic            det_L,
    input  logic            det_A,
    input  logic            det_at,
    input  logic            det_num,
    input  logic [3:0]      det_digit,
    input  logic            sec_tick,
    output logic            run,
    output logic [NDIG-1:0] ld_time,
    output logic [NDIG-1:0] ld_alm,
    output logic [CW-1:0]   alm_sel,
    output logic [NDIG-1:0] dsp,
    output logic [NDIG-1:0] str,
    output logic [NALM-1:0] alarm_ena
);
    localparam int            IW     = $clog2(NDIG);
    localparam logic [IW-1:0] LAST   = IW'(NDIG - 1);
    localparam logic [4:0]    NALM_W = 5'(NALM);
    localparam logic [7:0]    TO_LIM = 8'(TO_SEC);

    typedef enum logic [2:0] {
        STOP, RUN, LDT, LDT_DONE, ASEL, LDA, LDA_DONE, ATOG
    } state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   idx, idx_nxt;
    logic [NDIG-1:0] pos_oh, pos_msk, ld_time_c, ld_alm_c;
    logic [NALM-1:0] ena_tog;
    logic            sel_ld, dig_ok, chan_ok, dig_acc, timeout;

    // Even positions are tens digits (0..5); odd positions take any decimal digit.
    assign dig_ok  = det_num && (idx[0] || (det_digit <= 4'd5));
    assign chan_ok = det_num && ({1'b0, det_digit} < NALM_W);

    // Decode the digit pointer: one-hot for the strobe, thermometer for the display mask (p=0 is the MSB).
    always_comb begin
        pos_oh  = '0;
        pos_msk = '0;
        for (int p = 0; p < NDIG; p++) begin
            if (IW'(p) == idx) pos_oh[NDIG-1-p] = 1'b1;
            if (IW'(p) <= idx) pos_msk[NDIG-1-p] = 1'b1;
        end
    end

    // Next-state, digit pointer, Mealy load strobes and register update requests.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        ld_time_c = '0;
        ld_alm_c  = '0;
        sel_ld    = 1'b0;
        ena_tog   = '0;
        dig_acc   = 1'b0;
        if (timeout) begin
            state_nxt = STOP;
        end else begin
            case (state)
                STOP, RUN: begin
                    if (det_cr) state_nxt = STOP;
                    else if (det_S) state_nxt = RUN;
                    else if (det_L) begin
                        state_nxt = LDT;
                        idx_nxt   = '0;
                    end
                    else if (det_A) state_nxt = ASEL;
                    else if (det_at) state_nxt = ATOG;
                end
                LDT: begin
                    if (dig_ok) begin
                        ld_time_c = pos_oh;
                        dig_acc   = 1'b1;
                        if (idx == LAST) begin
                            state_nxt = LDT_DONE;
                            idx_nxt   = '0;
                        end else begin
                            idx_nxt = IW'(idx + 1);
                        end
                    end else if (det_cr) begin
                        state_nxt = STOP;
                    end
                end
                LDA: begin
                    if (dig_ok) begin
                        ld_alm_c = pos_oh;
                        dig_acc  = 1'b1;
                        if (idx == LAST) begin
                            state_nxt = LDA_DONE;
                            idx_nxt   = '0;
                        end else begin
                            idx_nxt = IW'(idx + 1);
                        end
                    end else if (det_cr) begin
                        state_nxt = STOP;
                    end
                end
                LDT_DONE: begin
                    if (det_S) state_nxt = RUN;
                    else if (det_cr) state_nxt = STOP;
                end
                LDA_DONE: begin
                    if (det_S) state_nxt = RUN;
                    else if (det_cr) state_nxt = STOP;
                    else if (det_A) state_nxt = ASEL;
                end
                ASEL: begin
                    if (chan_ok) begin
                        sel_ld    = 1'b1;
                        state_nxt = LDA;
                        idx_nxt   = '0;
                    end else if (det_cr) begin
                        state_nxt = STOP;
                    end
                end
                ATOG: begin
                    if (chan_ok) begin
                        for (int i = 0; i < NALM; i++) begin
                            if ({1'b0, det_digit} == 5'(i)) ena_tog[i] = 1'b1;
                        end
                        state_nxt = STOP;
                    end else if (det_cr) begin
                        state_nxt = STOP;
                    end
                end
                default: state_nxt = STOP;
            endcase
        end
    end

    // State, pointer, selected channel and alarm enables; reset wins over any same-cycle toggle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= STOP;
            idx       <= '0;
            alm_sel   <= '0;
            alarm_ena <= '0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            alarm_ena <= alarm_ena ^ ena_tog;
            if (sel_ld) alm_sel <= det_digit[CW-1:0];
        end
    end

`ifdef DIC_LOAD_TIMEOUT_EN
    logic [7:0] to_cnt;
    logic       timed;

    assign timed   = (state == LDT) || (state == LDA) || (state == ASEL) || (state == ATOG);
    assign timeout = timed && (to_cnt >= TO_LIM);

    // Seconds spent waiting in a load/select state; restarts on progress or any state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
        end else if ((state_nxt != state) || dig_acc) begin
            to_cnt <= '0;
        end else if (timed && sec_tick && (to_cnt != 8'hFF)) begin
            to_cnt <= to_cnt + 8'd1;
        end
    end
`else
    logic unused_to;
    assign timeout   = 1'b0;
    assign unused_to = sec_tick | (TO_LIM == 8'd0);
`endif

    // Strobes are suppressed while reset is held so an abandoned load writes nothing.
    assign ld_time = rst ? '0 : ld_time_c;
    assign ld_alm  = rst ? '0 : ld_alm_c;
    assign run     = (state == RUN);
    assign dsp     = (state == LDT) ? pos_msk : '1;
    assign str     = (state == LDA) ? pos_msk : ((state == LDA_DONE) ? '1 : '0);
endmodule

// File: tb/tb_dic_cmd_fsm.sv
// tb_dic_cmd_fsm: self-checking bench for dic_cmd_fsm with NDIG=4, NALM=2, TO_SEC=3.
// Load strobes are scoreboarded; level outputs are compared after each command.
// Inputs change 1 time unit after the rising edge; strobes are sampled on the falling edge.
module tb_dic_cmd_fsm;
    localparam int NDIG = 4;
    localparam int NALM = 2;
    localparam int TO_SEC = 3;
    localparam int CW = 1;

    localparam int K_CR = 0, K_S = 1, K_L = 2, K_A = 3, K_AT = 4, K_NUM = 5, K_TICK = 6;

    logic            clk = 1'b0;
    logic            rst;
    logic            det_cr, det_S, det_L, det_A, det_at, det_num, sec_tick;
    logic [3:0]      det_digit;
    logic            run;
    logic [NDIG-1:0] ld_time, ld_alm, dsp, str;
    logic [CW-1:0]   alm_sel;
    logic [NALM-1:0] alarm_ena;

    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0] q_lt[$];
    logic [3:0] q_la[$];

    dic_cmd_fsm #(.NDIG(NDIG), .NALM(NALM), .TO_SEC(TO_SEC), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .det_cr(det_cr), .det_S(det_S), .det_L(det_L), .det_A(det_A), .det_at(det_at),
        .det_num(det_num), .det_digit(det_digit), .sec_tick(sec_tick),
        .run(run), .ld_time(ld_time), .ld_alm(ld_alm), .alm_sel(alm_sel),
        .dsp(dsp), .str(str), .alarm_ena(alarm_ena)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_in();
        det_cr = 0; det_S = 0; det_L = 0; det_A = 0; det_at = 0;
        det_num = 0; det_digit = 4'd0; sec_tick = 0;
    endtask

    // Hold one command for exactly one clock cycle; consecutive calls are back-to-back.
    task automatic send(input int kind, input logic [3:0] d);
        case (kind)
            K_CR:   det_cr = 1;
            K_S:    det_S = 1;
            K_L:    det_L = 1;
            K_A:    det_A = 1;
            K_AT:   det_at = 1;
            K_NUM:  begin det_num = 1; det_digit = d; end
            default: sec_tick = 1;
        endcase
        @(posedge clk);
        #1;
        clr_in();
    endtask

    // Send a digit and record the strobe it should produce (0 = none).
    task automatic dig(input logic [3:0] d, input logic [3:0] exp_lt, input logic [3:0] exp_la);
        if (exp_lt != 4'd0) q_lt.push_back(exp_lt);
        if (exp_la != 4'd0) q_la.push_back(exp_la);
        send(K_NUM, d);
    endtask

    task automatic lvl(input string tag, input logic exp_run, input logic [3:0] exp_dsp,
                       input logic [3:0] exp_str);
        check({tag, "_run"}, run, exp_run);
        check({tag, "_dsp"}, dsp, exp_dsp);
        check({tag, "_str"}, str, exp_str);
    endtask

    // Scoreboard side: every strobe observed must match the oldest expected one.
    always @(negedge clk) begin
        if (ld_time != '0) begin
            if (q_lt.size() == 0) check("ld_time_unexpected", ld_time, 0);
            else check("ld_time", ld_time, q_lt.pop_front());
        end
        if (ld_alm != '0) begin
            if (q_la.size() == 0) check("ld_alm_unexpected", ld_alm, 0);
            else check("ld_alm", ld_alm, q_la.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_in();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        lvl("reset", 0, 4'b1111, 4'b0000);
        check("reset_alarm_ena", alarm_ena, 0);
        check("reset_alm_sel", alm_sel, 0);
        // reset beats a simultaneous S
        det_S = 1;
        @(posedge clk);
        #1;
        check("rst_prio_run", run, 0);
        clr_in();
        rst = 0;

        // S, cr, S
        send(K_S, 0);  lvl("s1", 1, 4'b1111, 4'b0000);
        send(K_CR, 0); lvl("cr1", 0, 4'b1111, 4'b0000);
        send(K_S, 0);  lvl("s2", 1, 4'b1111, 4'b0000);
        check("s_alarm_ena", alarm_ena, 0);

        // L 1 7 3 9 then S
        send(K_L, 0);         lvl("l_start", 0, 4'b1000, 4'b0000);
        dig(1, 4'b1000, 0);   check("l_d0_dsp", dsp, 4'b1100);
        dig(7, 4'b0100, 0);   check("l_d1_dsp", dsp, 4'b1110);
        dig(3, 4'b0010, 0);   check("l_d2_dsp", dsp, 4'b1111);
        dig(9, 4'b0001, 0);   lvl("l_done", 0, 4'b1111, 4'b0000);
        send(K_S, 0);         lvl("l_run", 1, 4'b1111, 4'b0000);

        // illegal tens digit ignored, then accepted digits
        send(K_CR, 0);
        send(K_L, 0);
        dig(7, 0, 0);         check("ill_p0_dsp", dsp, 4'b1000);
        send(K_S, 0);         check("ldt_ign_s_dsp", dsp, 4'b1000);
        dig(5, 4'b1000, 0);   check("p0_5_dsp", dsp, 4'b1100);
        dig(9, 4'b0100, 0);   check("p1_9_dsp", dsp, 4'b1110);
        send(K_CR, 0);        lvl("ldt_abort", 0, 4'b1111, 4'b0000);

        // A 1 2 0 0 0
        send(K_A, 0);         lvl("asel", 0, 4'b1111, 4'b0000);
        dig(1, 0, 0);         check("alm_sel_1", alm_sel, 1); check("lda_str0", str, 4'b1000);
        dig(2, 0, 4'b1000);   check("lda_str1", str, 4'b1100);
        dig(0, 0, 4'b0100);   check("lda_str2", str, 4'b1110);
        dig(0, 0, 4'b0010);   check("lda_str3", str, 4'b1111);
        dig(0, 0, 4'b0001);   lvl("lda_done", 0, 4'b1111, 4'b1111);
        send(K_CR, 0);        check("lda_cr_str", str, 0);

        // @ 1 toggles channel 1 on, again off
        send(K_AT, 0);
        dig(1, 0, 0);         check("tog_on", alarm_ena, 2'b10);
        send(K_AT, 0);
        dig(1, 0, 0);         check("tog_off", alarm_ena, 2'b00);

        // channel 5 is out of range with NALM=2
        send(K_A, 0);
        dig(5, 0, 0);         check("asel_bad_str", str, 0); check("asel_bad_sel", alm_sel, 1);
        dig(0, 0, 0);         check("alm_sel_0", alm_sel, 0); check("lda_ch0_str", str, 4'b1000);
        send(K_CR, 0);        check("cr_keep_sel", alm_sel, 0); lvl("asel_cr", 0, 4'b1111, 4'b0000);

        // back-to-back digits, one strobe per cycle
        send(K_L, 0);
        dig(2, 4'b1000, 0);
        dig(3, 4'b0100, 0);
        dig(4, 4'b0010, 0);
        dig(5, 4'b0001, 0);
        send(K_S, 0);         lvl("b2b_run", 1, 4'b1111, 4'b0000);

        // reset during a load: no strobe, back to idle
        send(K_CR, 0);
        send(K_AT, 0);
        dig(0, 0, 0);         check("tog_ch0", alarm_ena, 2'b01);
        send(K_L, 0);
        dig(1, 4'b1000, 0);
        rst = 1; det_num = 1; det_digit = 4'd2;
        @(posedge clk);
        #1;
        clr_in();
        rst = 0;
        lvl("rst_mid", 0, 4'b1111, 4'b0000);
        check("rst_mid_ena", alarm_ena, 0);
        dig(3, 0, 0);         check("post_rst_dsp", dsp, 4'b1111);

        // toggle and reset in the same cycle
        send(K_AT, 0);
        rst = 1; det_num = 1; det_digit = 4'd1;
        @(posedge clk);
        #1;
        clr_in();
        rst = 0;
        check("tog_rst_ena", alarm_ena, 0);

        // load timeout
        send(K_L, 0);
        dig(1, 4'b1000, 0);
        repeat (TO_SEC) begin
            send(K_TICK, 0);
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
`ifdef DIC_LOAD_TIMEOUT_EN
        lvl("timeout", 0, 4'b1111, 4'b0000);
        dig(2, 0, 0);         check("timeout_no_ld", dsp, 4'b1111);
`else
        lvl("no_timeout", 0, 4'b1100, 4'b0000);
        dig(2, 4'b0100, 0);   check("no_timeout_ld", dsp, 4'b1110);
        send(K_CR, 0);
`endif
        repeat (2) @(posedge clk);
        #1;
        check("q_lt_left", q_lt.size(), 0);
        check("q_la_left", q_la.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
